clock_group_reset_sequencer: RTL and testbench

- Parametrised successor to the single-member clock-group aggregator. Fans one clock domain out to N_MEMBERS members, each with its own reset and clock-enable.
- Synchronises reset deassertion and releases the members in order, with a programmable stagger between releases.
- Supports a per-member soft reset with a completion acknowledge. Sits between the top-level clock/reset source and the tile/bus clock groups.

---
 rtl/clock_group_pkg.sv | 23 ++
 rtl/reset_sync_chain.sv | 24 ++
 rtl/clock_group_reset_sequencer.sv | 178 +++++++++++++++++
 tb/tb_clock_group_reset_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_group_pkg.sv
// Clock-group reset sequencer shared types.
// Sequencer state and counter width helpers.
package clock_group_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } seq_state_e;

  function automatic int cnt_width(
    input int stagger
  );
    return $clog2(stagger + 1);
  endfunction

  function automatic int idx_width(
    input int n
  );
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Reset synchroniser: async assert, sync deassert.
// Output rises STAGES edges after reset release.
module reset_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_sync_o
);

  logic [STAGES-1:0] chain_q;

  // Shift ones in after release; assertion clears the chain at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Staggered reset release for N clock-group members,
// with per-member soft reset and completion ack.
module clock_group_reset_sequencer
  import clock_group_pkg::*;
#(
  parameter int N_MEMBERS   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STAGGER     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_MEMBERS-1:0] auto_in_reset_req,
  output logic [N_MEMBERS-1:0] auto_out_member_reset,
  output logic [N_MEMBERS-1:0] auto_out_member_clock_en,
  output logic [N_MEMBERS-1:0] auto_out_reset_ack,
  output logic                 seq_done
);

  localparam int CW = cnt_width(STAGGER);
  localparam int IW = idx_width(N_MEMBERS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_MEMBERS - 1);

  logic                 rst_sync;
  seq_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stall_q, stall_d;
  logic                 done_q;
  logic                 req_cur;
  logic [N_MEMBERS-1:0] rel_set;

  reset_sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i     (clock),
    .rst_ni    (reset),
    .rst_sync_o(rst_sync)
  );

  // Request of the member currently next in line.
  always_comb begin
    req_cur = 1'b0;
    for (int k = 0; k < N_MEMBERS; k++) begin
      if (idx_q == IW'(k)) begin
        req_cur = auto_in_reset_req[k];
      end
    end
  end

  // Release sequencer next state; a request at expiry stalls it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stall_d = stall_q;
    rel_set = '0;
    unique case (state_q)
      HOLD: begin
        if (rst_sync) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
          stall_d = 1'b0;
        end
      end
      RELEASE: begin
        if ((stall_q || cnt_q == CNT_LAST) && req_cur) begin
          cnt_d   = '0;
          stall_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          stall_d = 1'b0;
          idx_d   = idx_q + IW'(1);
          for (int k = 0; k < N_MEMBERS; k++) begin
            if (idx_q == IW'(k)) begin
              rel_set[k] = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          stall_d = 1'b0;
        end
      end
      RUN: begin
      end
      default: begin
        state_d = HOLD;
      end
    endcase
  end

  // Sequencer state register; done latches one cycle after RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stall_q <= stall_d;
      done_q  <= (state_q == RUN);
    end
  end

  assign seq_done = done_q;

  for (genvar k = 0; k < N_MEMBERS; k++) begin : g_member
    logic          rst_q, rst_d;
    logic          rel_q, rel_d;
    logic          tail_q, tail_d;
    logic          ack_q, ack_d;
    logic          cen_q;
    logic [CW-1:0] tcnt_q, tcnt_d;

    // Initial release, then soft-reset hold and tail once released.
    always_comb begin
      rst_d  = rst_q;
      rel_d  = rel_q;
      tail_d = tail_q;
      tcnt_d = tcnt_q;
      ack_d  = 1'b0;
      if (rel_set[k]) begin
        rst_d = 1'b0;
        rel_d = 1'b1;
      end else if (rel_q) begin
        if (auto_in_reset_req[k]) begin
          rst_d  = 1'b1;
          tail_d = 1'b0;
          tcnt_d = '0;
        end else if (tail_q) begin
          if (tcnt_q == CNT_LAST) begin
            rst_d  = 1'b0;
            tail_d = 1'b0;
            tcnt_d = '0;
            ack_d  = 1'b1;
          end else begin
            tcnt_d = tcnt_q + CW'(1);
          end
        end else if (rst_q) begin
          tail_d = 1'b1;
          tcnt_d = '0;
        end
      end
    end

    // Enable drops with reset, returns a cycle after it clears.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rst_q  <= 1'b1;
        rel_q  <= 1'b0;
        tail_q <= 1'b0;
        tcnt_q <= '0;
        ack_q  <= 1'b0;
        cen_q  <= 1'b0;
      end else begin
        rst_q  <= rst_d;
        rel_q  <= rel_d;
        tail_q <= tail_d;
        tcnt_q <= tcnt_d;
        ack_q  <= ack_d;
        cen_q  <= ~rst_q & ~rst_d;
      end
    end

    assign auto_out_member_reset[k]    = rst_q;
    assign auto_out_member_clock_en[k] = cen_q;
    assign auto_out_reset_ack[k]       = ack_q;
  end

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Bench for clock_group_reset_sequencer: directed
// scenarios plus random requests against a deadline model.
module tb_clock_group_reset_sequencer;

  localparam int N  = 4;
  localparam int SY = 2;
  localparam int S  = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N-1:0] mrst, men, mack;
  logic         done;
  logic [0:0]   req2  = '0;
  logic [0:0]   mrst2, men2, mack2;
  logic         done2;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  clock_group_reset_sequencer #(
    .N_MEMBERS(N), .SYNC_STAGES(SY), .STAGGER(S)
  ) dut (
    .clock                   (clk),
    .reset                   (rst_n),
    .auto_in_reset_req       (req),
    .auto_out_member_reset   (mrst),
    .auto_out_member_clock_en(men),
    .auto_out_reset_ack      (mack),
    .seq_done                (done)
  );

  clock_group_reset_sequencer #(
    .N_MEMBERS(1), .SYNC_STAGES(3), .STAGGER(1)
  ) dut2 (
    .clock                   (clk),
    .reset                   (rst_n),
    .auto_in_reset_req       (req2),
    .auto_out_member_reset   (mrst2),
    .auto_out_member_clock_en(men2),
    .auto_out_reset_ack      (mack2),
    .seq_done                (done2)
  );

  // Reference model: edge index t since release, absolute deadlines.
  int t;
  int nxt, due, fin;
  bit stalled;
  bit rel[N], mr[N], en[N], ak[N];
  int tail_end[N];
  bit d;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    asserts++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)",
             tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t = -1; nxt = 0; due = -1; fin = -1;
    stalled = 0; d = 0;
    for (int k = 0; k < N; k++) begin
      rel[k] = 0; mr[k] = 1; en[k] = 0; ak[k] = 0;
      tail_end[k] = -1;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    bit old_mr[N];
    t++;
    for (int k = 0; k < N; k++) begin
      old_mr[k] = mr[k];
      ak[k] = 0;
    end
    for (int k = 0; k < N; k++) begin
      if (rel[k]) begin
        if (r[k]) begin
          mr[k] = 1; tail_end[k] = -1;
        end else if (mr[k]) begin
          if (tail_end[k] < 0) tail_end[k] = t + S;
          else if (t == tail_end[k]) begin
            mr[k] = 0; ak[k] = 1; tail_end[k] = -1;
          end
        end
      end
    end
    if (t == SY) begin
      nxt = 0; due = SY + S; stalled = 0;
    end else if (t > SY && nxt < N) begin
      if (stalled && !r[nxt]) begin
        stalled = 0; due = t + S - 1;
      end
      if (!stalled && t == due) begin
        if (r[nxt]) stalled = 1;
        else begin
          mr[nxt] = 0; rel[nxt] = 1;
          if (nxt == N - 1) fin = t;
          nxt++;
          due = t + S;
        end
      end
    end
    for (int k = 0; k < N; k++) en[k] = !old_mr[k] && !mr[k];
    d = (fin >= 0) && (t > fin);
  endtask

  task automatic check_main();
    logic [N-1:0] er, ee, ea;
    for (int k = 0; k < N; k++) begin
      er[k] = mr[k]; ee[k] = en[k]; ea[k] = ak[k];
    end
    chk("member_reset", 32'(mrst), 32'(er));
    chk("clock_en", 32'(men), 32'(ee));
    chk("reset_ack", 32'(mack), 32'(ea));
    chk("seq_done", 32'(done), 32'(d));
  endtask

  task automatic step();
    logic [N-1:0] r;
    r = req;
    @(posedge clk);
    model_edge(r);
    #1;
    check_main();
  endtask

  task automatic apply_reset(input int low_cycles);
    rst_n = 1'b0;
    req   = '0;
    req2  = '0;
    #1;
    chk("async_member_reset", 32'(mrst), 32'({N{1'b1}}));
    chk("async_clock_en", 32'(men), 32'd0);
    chk("async_reset_ack", 32'(mack), 32'd0);
    chk("async_seq_done", 32'(done), 32'd0);
    repeat (low_cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int tdone, f0, f1, f2, f3, nack, tack, rise1;
    logic [2:0] d2_tbl [4];
    d2_tbl = '{3'b100, 3'b100, 3'b001, 3'b010};
    model_reset();
    #2;
    apply_reset(3);

    // Power-on with no requests; small instance checked too.
    tdone = -1;
    repeat (45) begin
      step();
      if (done && tdone < 0) tdone = t;
      chk("d2_reset", 32'(mrst2), 32'(t < 4));
      chk("d2_clock_en", 32'(men2), 32'(t >= 5));
      chk("d2_seq_done", 32'(done2), 32'(t >= 5));
      chk("d2_ack", 32'(mack2), 32'd0);
    end
    chk("seq_done_edge", 32'(tdone), 32'(SY + N * S + 1));

    // One-cycle soft reset on the STAGGER=1 instance.
    req2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      req2 = 1'b0;
      chk("d2_soft", 32'({mrst2, men2, mack2}), 32'(d2_tbl[i]));
    end

    // Member 2 requests through edge 40 of the initial sequence.
    apply_reset(2);
    req[2] = 1'b1;
    f2 = -1; f3 = -1; tdone = -1;
    while (t < 40) step();
    req[2] = 1'b0;
    while (t < 90) begin
      step();
      if (!mrst[2] && f2 < 0) f2 = t;
      if (!mrst[3] && f3 < 0) f3 = t;
      if (done && tdone < 0) tdone = t;
    end
    chk("stall_m2_release", 32'(f2), 32'd48);
    chk("stall_m3_release", 32'(f3), 32'd56);
    chk("stall_seq_done", 32'(tdone), 32'd57);

    // Soft reset of member 1 in RUN, request edges 100..104.
    while (t < 99) step();
    req[1] = 1'b1;
    rise1 = -1; f1 = -1; nack = 0; tack = -1;
    while (t < 130) begin
      step();
      if (t == 104) req[1] = 1'b0;
      if (mrst[1] && rise1 < 0) rise1 = t;
      if (rise1 >= 0 && !mrst[1] && f1 < 0) f1 = t;
      if (mack[1]) begin nack++; tack = t; end
    end
    chk("soft_m1_rise", 32'(rise1), 32'd100);
    chk("soft_m1_fall", 32'(f1), 32'd113);
    chk("soft_m1_ack_cnt", 32'(nack), 32'd1);
    chk("soft_m1_ack_t", 32'(tack), 32'd113);

    // Member 0 tail interrupted: low 200, high 203, low 210.
    while (t < 194) step();
    req[0] = 1'b1;
    f0 = -1; nack = 0; tack = -1;
    while (t < 240) begin
      step();
      if (t == 199 || t == 209) req[0] = 1'b0;
      if (t == 202) req[0] = 1'b1;
      if (t >= 200 && !mrst[0] && f0 < 0) f0 = t;
      if (mack[0]) begin nack++; tack = t; end
    end
    chk("retail_m0_fall", 32'(f0), 32'd218);
    chk("retail_ack_cnt", 32'(nack), 32'd1);
    chk("retail_ack_t", 32'(tack), 32'd218);

    // Reset pulse mid-sequence restarts from HOLD.
    apply_reset(1);
    while (t < 30) step();
    apply_reset(0);
    f0 = -1;
    while (t < 45) begin
      step();
      if (!mrst[0] && f0 < 0) f0 = t;
    end
    chk("restart_m0_fall", 32'(f0), 32'(SY + S));

    // Random request traffic, including resets mid-sequence.
    for (int r = 0; r < 5; r++) begin
      apply_reset($urandom_range(0, 3));
      repeat ($urandom_range(25, 320)) begin
        for (int k = 0; k < N; k++) begin
          if ($urandom_range(0, 13) == 0) req[k] = ~req[k];
        end
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
